// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for the two-port BlockRam arbiter: FSM state encoding,
// port identifiers and the one-hot grant codes.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

package memory_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_t;

   // grant is one-hot {B,A}; all-zero means no port owns the bus
   localparam logic [1:0] GRANT_NONE   = 2'b00;
   localparam logic [1:0] GRANT_PORT_A = 2'b01;
   localparam logic [1:0] GRANT_PORT_B = 2'b10;

   function automatic logic [1:0] grant_of(input port_t p);
      return (p == PORT_A) ? GRANT_PORT_A : GRANT_PORT_B;
   endfunction

endpackage

// File: rtl/memory_port_arbiter_mux.sv
// Combinational 2:1 routing between the two requesters and the BlockRam port,
// steered by the one-hot grant; the unselected side always sees zeros.
module memory_port_arbiter_mux
   import memory_port_arbiter_pkg::*;
#(
   parameter int MADDR_WIDTH = 16,
   parameter int MDATA_WIDTH = 32
) (
   input  logic [1:0]             grant,
   input  logic                   a_read_enable,
   input  logic                   a_write_enable,
   input  logic [MADDR_WIDTH-1:0] a_addr,
   input  logic [MDATA_WIDTH-1:0] a_write_data,
   output logic                   a_read_ready,
   output logic                   a_write_ready,
   output logic [MDATA_WIDTH-1:0] a_read_data,
   input  logic                   b_read_enable,
   input  logic                   b_write_enable,
   input  logic [MADDR_WIDTH-1:0] b_addr,
   input  logic [MDATA_WIDTH-1:0] b_write_data,
   output logic                   b_read_ready,
   output logic                   b_write_ready,
   output logic [MDATA_WIDTH-1:0] b_read_data,
   output logic                   mem_read_enable,
   output logic                   mem_write_enable,
   output logic [MADDR_WIDTH-1:0] mem_addr,
   output logic [MDATA_WIDTH-1:0] mem_write_data,
   input  logic                   mem_read_ready,
   input  logic                   mem_write_ready,
   input  logic [MDATA_WIDTH-1:0] mem_read_data
);

   always_comb begin
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      mem_addr         = '0;
      mem_write_data   = '0;
      a_read_ready     = 1'b0;
      a_write_ready    = 1'b0;
      a_read_data      = '0;
      b_read_ready     = 1'b0;
      b_write_ready    = 1'b0;
      b_read_data      = '0;
      if (grant == GRANT_PORT_A) begin
         mem_read_enable  = a_read_enable;
         mem_write_enable = a_write_enable;
         mem_addr         = a_addr;
         mem_write_data   = a_write_data;
         a_read_ready     = mem_read_ready;
         a_write_ready    = mem_write_ready;
         a_read_data      = mem_read_data;
      end else if (grant == GRANT_PORT_B) begin
         mem_read_enable  = b_read_enable;
         mem_write_enable = b_write_enable;
         mem_addr         = b_addr;
         mem_write_data   = b_write_data;
         b_read_ready     = mem_read_ready;
         b_write_ready    = mem_write_ready;
         b_read_data      = mem_read_data;
      end
   end

endmodule

// File: rtl/memory_port_arbiter.sv
// Round-robin owner of the single BlockRam port: one requester holds the bus for a
// whole four-phase transaction, then the bus drains before the next grant.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module memory_port_arbiter
   import memory_port_arbiter_pkg::*;
#(
   parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
   parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   a_read_enable,
   input  logic                   a_write_enable,
   input  logic [MADDR_WIDTH-1:0] a_addr,
   input  logic [MDATA_WIDTH-1:0] a_write_data,
   output logic                   a_read_ready,
   output logic                   a_write_ready,
   output logic [MDATA_WIDTH-1:0] a_read_data,
   input  logic                   b_read_enable,
   input  logic                   b_write_enable,
   input  logic [MADDR_WIDTH-1:0] b_addr,
   input  logic [MDATA_WIDTH-1:0] b_write_data,
   output logic                   b_read_ready,
   output logic                   b_write_ready,
   output logic [MDATA_WIDTH-1:0] b_read_data,
   output logic                   mem_read_enable,
   output logic                   mem_write_enable,
   output logic [MADDR_WIDTH-1:0] mem_addr,
   output logic [MDATA_WIDTH-1:0] mem_write_data,
   input  logic                   mem_read_ready,
   input  logic                   mem_write_ready,
   input  logic [MDATA_WIDTH-1:0] mem_read_data,
   output logic [1:0]             grant,
   output logic                   busy
);

   state_t     state_reg;
   port_t      last_served_reg;
   logic [1:0] grant_reg;
   logic       busy_reg;
   logic       req_a;
   logic       req_b;

   assign req_a = a_read_enable | a_write_enable;
   assign req_b = b_read_enable | b_write_enable;

   // grant and busy are registered alongside the state so they drop with reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg       <= IDLE;
         last_served_reg <= PORT_B;
         grant_reg       <= GRANT_NONE;
         busy_reg        <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_a && (!req_b || last_served_reg == PORT_B)) begin
                  state_reg <= GRANT_A;
                  grant_reg <= grant_of(PORT_A);
                  busy_reg  <= 1'b1;
               end else if (req_b) begin
                  state_reg <= GRANT_B;
                  grant_reg <= grant_of(PORT_B);
                  busy_reg  <= 1'b1;
               end
            end
            GRANT_A: begin
               if (!req_a) begin
                  state_reg       <= DRAIN;
                  last_served_reg <= PORT_A;
                  grant_reg       <= GRANT_NONE;
               end
            end
            GRANT_B: begin
               if (!req_b) begin
                  state_reg       <= DRAIN;
                  last_served_reg <= PORT_B;
                  grant_reg       <= GRANT_NONE;
               end
            end
            DRAIN: begin
               // the BlockRam must finish its own return-to-zero before a new owner
               if (!mem_read_ready && !mem_write_ready) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               grant_reg <= GRANT_NONE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign grant = grant_reg;
   assign busy  = busy_reg;

   memory_port_arbiter_mux #(
      .MADDR_WIDTH(MADDR_WIDTH),
      .MDATA_WIDTH(MDATA_WIDTH)
   ) u_mux (
      .grant           (grant_reg),
      .a_read_enable   (a_read_enable),
      .a_write_enable  (a_write_enable),
      .a_addr          (a_addr),
      .a_write_data    (a_write_data),
      .a_read_ready    (a_read_ready),
      .a_write_ready   (a_write_ready),
      .a_read_data     (a_read_data),
      .b_read_enable   (b_read_enable),
      .b_write_enable  (b_write_enable),
      .b_addr          (b_addr),
      .b_write_data    (b_write_data),
      .b_read_ready    (b_read_ready),
      .b_write_ready   (b_write_ready),
      .b_read_data     (b_read_data),
      .mem_read_enable (mem_read_enable),
      .mem_write_enable(mem_write_enable),
      .mem_addr        (mem_addr),
      .mem_write_data  (mem_write_data),
      .mem_read_ready  (mem_read_ready),
      .mem_write_ready (mem_write_ready),
      .mem_read_data   (mem_read_data)
   );

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: a behavioural BlockRam with random handshake latency,
// two four-phase requesters and a scoreboard of memory contents and grant order.
module tb_memory_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int OW = 2 + AW + DW + 2 * (2 + DW) + 3;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          a_read_enable = 1'b0, a_write_enable = 1'b0;
   logic [AW-1:0] a_addr = '0;
   logic [DW-1:0] a_write_data = '0;
   logic          a_read_ready, a_write_ready;
   logic [DW-1:0] a_read_data;
   logic          b_read_enable = 1'b0, b_write_enable = 1'b0;
   logic [AW-1:0] b_addr = '0;
   logic [DW-1:0] b_write_data = '0;
   logic          b_read_ready, b_write_ready;
   logic [DW-1:0] b_read_data;
   logic          mem_read_enable, mem_write_enable;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_write_data;
   logic          m_rr, m_wr;
   logic [DW-1:0] m_rd;
   logic [1:0]    grant;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [1:0]    grant_log[$];
   int            gcyc_log[$];
   logic [DW-1:0] ref_mem[int];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   memory_port_arbiter #(.MADDR_WIDTH(AW), .MDATA_WIDTH(DW)) dut (
      .clock(clock), .reset(reset),
      .a_read_enable(a_read_enable), .a_write_enable(a_write_enable),
      .a_addr(a_addr), .a_write_data(a_write_data),
      .a_read_ready(a_read_ready), .a_write_ready(a_write_ready), .a_read_data(a_read_data),
      .b_read_enable(b_read_enable), .b_write_enable(b_write_enable),
      .b_addr(b_addr), .b_write_data(b_write_data),
      .b_read_ready(b_read_ready), .b_write_ready(b_write_ready), .b_read_data(b_read_data),
      .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read_ready(m_rr), .mem_write_ready(m_wr), .mem_read_data(m_rd),
      .grant(grant), .busy(busy)
   );

   // BlockRam model: each handshake phase completes after 0..2 extra cycles
   logic [DW-1:0] bram [0:255];
   int unsigned   lat;
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_rr <= 1'b0; m_wr <= 1'b0; m_rd <= '0; lat <= 0;
      end else if ((mem_read_enable | mem_write_enable) != (m_rr | m_wr)) begin
         if (lat != 0) begin
            lat <= lat - 1;
         end else begin
            lat <= $urandom_range(0, 2);
            if (mem_read_enable | mem_write_enable) begin
               m_rr <= mem_read_enable;
               m_wr <= mem_write_enable;
               m_rd <= bram[mem_addr[7:0]];
               if (mem_write_enable) bram[mem_addr[7:0]] <= mem_write_data;
            end else begin
               m_rr <= 1'b0; m_wr <= 1'b0; m_rd <= '0;
            end
         end
      end
   end

   function automatic logic [OW-1:0] outputs_vec();
      return {mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
              a_read_ready, a_write_ready, a_read_data,
              b_read_ready, b_write_ready, b_read_data, grant, busy};
   endfunction

   function automatic logic port_ready(input bit port, input bit wr);
      if (port) return wr ? b_write_ready : b_read_ready;
      return wr ? a_write_ready : a_read_ready;
   endfunction

   // Watches every cycle: routing follows the owner, the idle side is silent, grant order logged
   task automatic monitor();
      logic [1:0] prev;
      prev = 2'b00;
      forever begin
         @(negedge clock);
         if (!reset) begin
            prev = 2'b00;
         end else begin
            checks++;
            if (grant == 2'b01) begin
               if ({mem_read_enable, mem_write_enable, mem_addr, mem_write_data} !==
                   {a_read_enable, a_write_enable, a_addr, a_write_data} ||
                   {a_read_ready, a_write_ready, a_read_data} !== {m_rr, m_wr, m_rd} ||
                   {b_read_ready, b_write_ready, b_read_data} !== '0 || busy !== 1'b1) begin
                  errors++;
                  $display("FAIL route_a @%0d: mem addr=%h en=%b%b b_rdy=%b%b, required addr=%h en=%b%b b_rdy=00",
                           cyc, mem_addr, mem_read_enable, mem_write_enable, b_read_ready, b_write_ready,
                           a_addr, a_read_enable, a_write_enable);
               end
            end else if (grant == 2'b10) begin
               if ({mem_read_enable, mem_write_enable, mem_addr, mem_write_data} !==
                   {b_read_enable, b_write_enable, b_addr, b_write_data} ||
                   {b_read_ready, b_write_ready, b_read_data} !== {m_rr, m_wr, m_rd} ||
                   {a_read_ready, a_write_ready, a_read_data} !== '0 || busy !== 1'b1) begin
                  errors++;
                  $display("FAIL route_b @%0d: mem addr=%h en=%b%b a_rdy=%b%b, required addr=%h en=%b%b a_rdy=00",
                           cyc, mem_addr, mem_read_enable, mem_write_enable, a_read_ready, a_write_ready,
                           b_addr, b_read_enable, b_write_enable);
               end
            end else if (grant == 2'b00) begin
               if ({mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
                    a_read_ready, a_write_ready, a_read_data,
                    b_read_ready, b_write_ready, b_read_data} !== '0) begin
                  errors++;
                  $display("FAIL idle_quiet @%0d: mem addr=%h en=%b%b rdy a=%b%b b=%b%b, required all zero",
                           cyc, mem_addr, mem_read_enable, mem_write_enable,
                           a_read_ready, a_write_ready, b_read_ready, b_write_ready);
               end
            end else begin
               errors++;
               $display("FAIL grant_onehot @%0d: grant=%b, required 00/01/10", cyc, grant);
            end
            if (grant != 2'b00 && prev == 2'b00) begin
               grant_log.push_back(grant);
               gcyc_log.push_back(cyc);
            end
            prev = grant;
         end
      end
   endtask

   // One complete four-phase transaction from requester 'port' (0=A, 1=B)
   task automatic xact(input bit port, input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                       output int req_cyc, output int gnt_cyc);
      bit done;
      @(posedge clock); #1;
      if (!port) begin
         a_addr = addr; a_write_data = wdata; a_read_enable = !wr; a_write_enable = wr;
      end else begin
         b_addr = addr; b_write_data = wdata; b_read_enable = !wr; b_write_enable = wr;
      end
      req_cyc = cyc;
      gnt_cyc = -1;
      rdata = '0;
      done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clock);
         if (gnt_cyc < 0 && grant[port]) gnt_cyc = cyc;
         if (port_ready(port, wr)) begin
            done = 1'b1;
            rdata = port ? b_read_data : a_read_data;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL ready_up_timeout: port=%0d ready=0, required 1 within 200 cycles", port);
      end
      @(posedge clock); #1;
      if (!port) begin a_read_enable = 1'b0; a_write_enable = 1'b0; end
      else begin b_read_enable = 1'b0; b_write_enable = 1'b0; end
      done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clock);
         done = !port_ready(port, wr);
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL ready_down_timeout: port=%0d ready=1, required 0 within 200 cycles", port);
      end
      $display("xact port=%s %s addr=%h data=%h req@%0d gnt@%0d",
               port ? "B" : "A", wr ? "WR" : "RD", addr, wr ? wdata : rdata, req_cyc, gnt_cyc);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         {a_read_enable, a_write_enable, b_read_enable, b_write_enable} = 4'($urandom);
         a_addr = AW'($urandom); b_addr = AW'($urandom);
         a_write_data = $urandom; b_write_data = $urandom;
         @(negedge clock);
         checks++;
         if (outputs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: outputs=%h, required 0", outputs_vec());
         end
      end
      {a_read_enable, a_write_enable, b_read_enable, b_write_enable} = 4'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (grant !== 2'b00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: grant=%b busy=%b, required grant=00 busy=0", grant, busy);
      end
   endtask

   task automatic test_single_write();
      logic [DW-1:0] rd;
      int q, g;
      grant_log.delete(); gcyc_log.delete();
      xact(1'b1, 1'b1, 16'h0010, 32'h0000_005A, rd, q, g);
      ref_mem[16'h0010] = 32'h0000_005A;
      checks++;
      if (g - q !== 1) begin
         errors++;
         $display("FAIL write_grant_latency: %0d cycles, required 1", g - q);
      end
      checks++;
      if (grant_log.size() != 1 || grant_log[0] !== 2'b10) begin
         errors++;
         $display("FAIL write_grant: grants=%0d first=%b, required 1 grant of 10", grant_log.size(), grant_log[0]);
      end
      xact(1'b0, 1'b0, 16'h0010, '0, rd, q, g);
      checks++;
      if (rd !== ref_mem[16'h0010]) begin
         errors++;
         $display("FAIL readback_a: data=%h, required %h", rd, ref_mem[16'h0010]);
      end
   endtask

   task automatic test_simultaneous();
      logic [DW-1:0] ra, rb, wd;
      int qa, ga, qb, gb;
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      wd = $urandom;
      grant_log.delete(); gcyc_log.delete();
      fork
         xact(1'b0, 1'b0, 16'h0000, '0, ra, qa, ga);
         xact(1'b1, 1'b1, 16'h0004, wd, rb, qb, gb);
      join
      ref_mem[16'h0004] = wd;
      checks++;
      if (grant_log.size() != 2 || grant_log[0] !== 2'b01 || grant_log[1] !== 2'b10) begin
         errors++;
         $display("FAIL tie_order: n=%0d first=%b second=%b, required 01 then 10",
                  grant_log.size(), grant_log[0], grant_log[1]);
      end
      checks++;
      if (ga - qa !== 1 || gb - ga < 3) begin
         errors++;
         $display("FAIL tie_timing: A latency=%0d B after A=%0d, required 1 and >=3", ga - qa, gb - ga);
      end
   endtask

   task automatic test_round_robin();
      logic [DW-1:0] ra, rb, da, db;
      logic [AW-1:0] aa, ab;
      int qa, ga, qb, gb;
      grant_log.delete(); gcyc_log.delete();
      fork
         for (int i = 0; i < 2; i++) begin
            aa = AW'(16'h0020 + $urandom_range(0, 15)); da = $urandom;
            xact(1'b0, 1'b1, aa, da, ra, qa, ga);
            ref_mem[int'(aa)] = da;
         end
         for (int i = 0; i < 2; i++) begin
            ab = AW'(16'h0030 + $urandom_range(0, 15)); db = $urandom;
            xact(1'b1, 1'b1, ab, db, rb, qb, gb);
            ref_mem[int'(ab)] = db;
         end
      join
      checks++;
      if (grant_log.size() != 4 || grant_log[0] !== 2'b01 || grant_log[1] !== 2'b10 ||
          grant_log[2] !== 2'b01 || grant_log[3] !== 2'b10) begin
         errors++;
         $display("FAIL rr_order: n=%0d seq=%b,%b,%b,%b, required 01,10,01,10", grant_log.size(),
                  grant_log[0], grant_log[1], grant_log[2], grant_log[3]);
      end
      for (int i = 1; i < gcyc_log.size(); i++) begin
         checks++;
         if (gcyc_log[i] - gcyc_log[i-1] < 3) begin
            errors++;
            $display("FAIL rr_spacing: gap=%0d, required >=3", gcyc_log[i] - gcyc_log[i-1]);
         end
      end
   endtask

   task automatic test_hold_off();
      logic [DW-1:0] ra, rb;
      int qa, ga, qb, gb;
      grant_log.delete(); gcyc_log.delete();
      fork
         xact(1'b0, 1'b0, 16'h0010, '0, ra, qa, ga);
         begin
            @(posedge clock);
            xact(1'b1, 1'b0, 16'h0004, '0, rb, qb, gb);
         end
      join
      checks++;
      if (ra !== ref_mem[16'h0010] || rb !== ref_mem[16'h0004]) begin
         errors++;
         $display("FAIL holdoff_data: a=%h b=%h, required a=%h b=%h", ra, rb,
                  ref_mem[16'h0010], ref_mem[16'h0004]);
      end
      checks++;
      if (grant_log.size() != 2 || grant_log[0] !== 2'b01 || grant_log[1] !== 2'b10 || gb - ga < 3) begin
         errors++;
         $display("FAIL holdoff_order: n=%0d first=%b gap=%0d, required 01 then 10 with gap>=3",
                  grant_log.size(), grant_log[0], gb - ga);
      end
   endtask

   task automatic test_random_traffic();
      logic [DW-1:0] rd, wd;
      logic [AW-1:0] ad;
      int q, g;
      bit pw, pr;
      for (int i = 0; i < 6; i++) begin
         pw = 1'($urandom); pr = 1'($urandom);
         ad = AW'(16'h0040 + $urandom_range(0, 63));
         wd = $urandom;
         xact(pw, 1'b1, ad, wd, rd, q, g);
         ref_mem[int'(ad)] = wd;
         xact(pr, 1'b0, ad, '0, rd, q, g);
         checks++;
         if (rd !== ref_mem[int'(ad)]) begin
            errors++;
            $display("FAIL random_readback: port=%0d addr=%h data=%h, required %h", pr, ad, rd, ref_mem[int'(ad)]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] rd;
      int q, g;
      bit seen;
      @(posedge clock); #1;
      a_addr = 16'h0010; a_read_enable = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clock);
         seen = (grant == 2'b01 && m_rr == 1'b1);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL midreset_setup: grant=%b mem_read_ready=%b, required 01 and 1", grant, m_rr);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (outputs_vec() !== '0) begin
         errors++;
         $display("FAIL midreset_async: outputs=%h, required 0 before any edge", outputs_vec());
      end
      a_read_enable = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      grant_log.delete(); gcyc_log.delete();
      xact(1'b0, 1'b0, 16'h0010, '0, rd, q, g);
      checks++;
      if (rd !== ref_mem[16'h0010] || g - q !== 1 || grant_log.size() != 1) begin
         errors++;
         $display("FAIL midreset_restart: data=%h latency=%0d grants=%0d, required %h 1 1",
                  rd, g - q, grant_log.size(), ref_mem[16'h0010]);
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_single_write();
      test_simultaneous();
      test_round_robin();
      test_hold_off();
      test_random_traffic();
      test_reset_mid();
      repeat (3) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
